// File: rtl/junctions_pkg.sv
// Shared junction-fabric types and helpers: R response codes, arbiter FSM states,
// round-robin search and width helpers.
package junctions_pkg;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_EXOKAY = 2'b01,
    RESP_SLVERR = 2'b10,
    RESP_DECERR = 2'b11
  } resp_e;

  typedef enum logic {
    ARB_IDLE  = 1'b0,
    ARB_BURST = 1'b1
  } arb_state_e;

  localparam int RR_MAX_N = 64;
  localparam int RR_IDX_W = 6;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int cnt_w(input int max_beats);
    return $clog2(max_beats + 1);
  endfunction

  // First set bit of mask scanning from ptr+1 with wrap over n entries;
  // with nothing set the pointer still advances to (ptr+1) mod n.
  function automatic int rr_next(input logic [RR_MAX_N-1:0] mask, input int ptr, input int n);
    int  res;
    int  idx;
    bit  found;
    res   = (ptr + 1) % n;
    found = 1'b0;
    for (int k = 0; k < RR_MAX_N; k++) begin
      if (k < n && !found) begin
        idx = (ptr + 1 + k) % n;
        if (mask[idx[RR_IDX_W-1:0]]) begin
          res   = idx;
          found = 1'b1;
        end
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/junctions_skid_slice.sv
// Two-entry valid/ready skid buffer: one cycle latency, full throughput, registered in_ready.
// Upstream sees ready drop only once the skid entry is occupied by a stalled beat.
module junctions_skid_slice #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  logic [W-1:0] skid_data;
  logic         skid_valid;

  assign in_ready = !skid_valid;

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid  <= 1'b0;
      skid_valid <= 1'b0;
    end else if (out_ready || !out_valid) begin
      if (skid_valid) begin
        out_valid  <= 1'b1;
        out_data   <= skid_data;
        skid_valid <= 1'b0;
      end else begin
        out_valid <= in_valid;
        if (in_valid) out_data <= in_data;
      end
    end else if (in_valid && !skid_valid) begin
      // Output stalled: park the accepted beat so in_ready can be a flop.
      skid_valid <= 1'b1;
      skid_data  <= in_data;
    end
  end

endmodule

// File: rtl/junctions_rr_burst_arbiter.sv
// N_IN:1 round-robin R-beat arbiter holding the grant for a whole burst; zero latency by default,
// or one cycle through a skid slice when JUNC_ARB_OUT_SLICE_EN is defined. Only the selected input sees ready.
module junctions_rr_burst_arbiter
  import junctions_pkg::*;
#(
  parameter int N_IN      = 4,
  parameter int DATA_W    = 64,
  parameter int ID_W      = 6,
  parameter int USER_W    = 1,
  parameter int RESP_W    = 2,
  parameter int MAX_BEATS = 256
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [N_IN-1:0]           io_in_valid,
  output logic [N_IN-1:0]           io_in_ready,
  input  logic [N_IN*DATA_W-1:0]    io_in_bits_data,
  input  logic [N_IN*RESP_W-1:0]    io_in_bits_resp,
  input  logic [N_IN*ID_W-1:0]      io_in_bits_id,
  input  logic [N_IN*USER_W-1:0]    io_in_bits_user,
  input  logic [N_IN-1:0]           io_in_bits_last,
  input  logic                      io_out_ready,
  output logic                      io_out_valid,
  output logic [DATA_W-1:0]         io_out_bits_data,
  output logic [RESP_W-1:0]         io_out_bits_resp,
  output logic [ID_W-1:0]           io_out_bits_id,
  output logic [USER_W-1:0]         io_out_bits_user,
  output logic                      io_out_bits_last,
  output logic [$clog2(N_IN)-1:0]   grant_idx,
  output logic                      locked,
  output logic                      err_burst_len,
  input  logic                      err_clr
);

  localparam int IDX_W = idx_w(N_IN);
  localparam int CNT_W = cnt_w(MAX_BEATS);

  // One spare bit so the saturation value MAX_BEATS+1 always fits.
  typedef logic [CNT_W:0] cnt_t;
  localparam cnt_t CNT_MAX = cnt_t'(MAX_BEATS);
  localparam cnt_t CNT_SAT = cnt_t'(MAX_BEATS + 1);

  arb_state_e           state;
  logic [IDX_W-1:0]     last_grant;
  cnt_t                 beat_cnt;
  logic [IDX_W-1:0]     sel;
  logic [RR_MAX_N-1:0]  vmask;

  logic                 sel_valid;
  logic [DATA_W-1:0]    sel_data;
  logic [RESP_W-1:0]    sel_resp;
  logic [ID_W-1:0]      sel_id;
  logic [USER_W-1:0]    sel_user;
  logic                 sel_last;

  logic                 acc_rdy;
  logic                 adv;
  logic                 err_set;

  assign vmask = RR_MAX_N'(io_in_valid);

  always_comb begin
    sel = last_grant;
    if (!locked) sel = IDX_W'(rr_next(vmask, int'(last_grant), N_IN));
  end

  always_comb begin
    sel_valid = 1'b0;
    sel_data  = '0;
    sel_resp  = '0;
    sel_id    = '0;
    sel_user  = '0;
    sel_last  = 1'b0;
    for (int i = 0; i < N_IN; i++) begin
      if (sel == IDX_W'(i)) begin
        sel_valid = io_in_valid[i];
        sel_data  = io_in_bits_data[i*DATA_W +: DATA_W];
        sel_resp  = io_in_bits_resp[i*RESP_W +: RESP_W];
        sel_id    = io_in_bits_id[i*ID_W +: ID_W];
        sel_user  = io_in_bits_user[i*USER_W +: USER_W];
        sel_last  = io_in_bits_last[i];
      end
    end
  end

`ifdef JUNC_ARB_OUT_SLICE_EN
  localparam int BEAT_W = DATA_W + RESP_W + ID_W + USER_W + 1;
  logic [BEAT_W-1:0] slice_out;

  junctions_skid_slice #(.W(BEAT_W)) u_slice (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (sel_valid),
    .in_ready  (acc_rdy),
    .in_data   ({sel_data, sel_resp, sel_id, sel_user, sel_last}),
    .out_valid (io_out_valid),
    .out_ready (io_out_ready),
    .out_data  (slice_out)
  );

  assign {io_out_bits_data, io_out_bits_resp, io_out_bits_id,
          io_out_bits_user, io_out_bits_last} = slice_out;
`else
  assign acc_rdy          = io_out_ready;
  assign io_out_valid     = sel_valid;
  assign io_out_bits_data = sel_data;
  assign io_out_bits_resp = sel_resp;
  assign io_out_bits_id   = sel_id;
  assign io_out_bits_user = sel_user;
  assign io_out_bits_last = sel_last;
`endif

  always_comb begin
    io_in_ready = '0;
    for (int i = 0; i < N_IN; i++) io_in_ready[i] = acc_rdy & (sel == IDX_W'(i));
  end

  assign adv       = sel_valid & acc_rdy;
  assign err_set   = adv & (beat_cnt >= CNT_MAX);
  assign grant_idx = sel;

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= ARB_IDLE;
      locked        <= 1'b0;
      last_grant    <= IDX_W'(N_IN - 1);
      beat_cnt      <= '0;
      err_burst_len <= 1'b0;
    end else begin
      if (err_set)      err_burst_len <= 1'b1;
      else if (err_clr) err_burst_len <= 1'b0;

      if (adv) begin
        if (state == ARB_IDLE) begin
          last_grant <= sel;
          if (!sel_last) begin
            state    <= ARB_BURST;
            locked   <= 1'b1;
            beat_cnt <= cnt_t'(1);
          end
        end else if (sel_last) begin
          state    <= ARB_IDLE;
          locked   <= 1'b0;
          beat_cnt <= '0;
        end else if (beat_cnt < CNT_SAT) begin
          beat_cnt <= beat_cnt + cnt_t'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_junctions_rr_burst_arbiter.sv
// Scoreboarded bench: directed per-channel beat lists, expected output order pushed by the stimulus,
// popped by an independent output monitor; arbitration state checked directly per cycle.
module tb_junctions_rr_burst_arbiter;

  localparam int N = 4, DW = 16, IW = 4, UW = 1, RW = 2, MB = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset;
  logic [N-1:0]      io_in_valid, io_in_ready, io_in_bits_last;
  logic [N*DW-1:0]   io_in_bits_data;
  logic [N*RW-1:0]   io_in_bits_resp;
  logic [N*IW-1:0]   io_in_bits_id;
  logic [N*UW-1:0]   io_in_bits_user;
  logic              io_out_ready, io_out_valid, io_out_bits_last;
  logic [DW-1:0]     io_out_bits_data;
  logic [RW-1:0]     io_out_bits_resp;
  logic [IW-1:0]     io_out_bits_id;
  logic [UW-1:0]     io_out_bits_user;
  logic [1:0]        grant_idx;
  logic              locked, err_burst_len, err_clr;

  junctions_rr_burst_arbiter #(
    .N_IN(N), .DATA_W(DW), .ID_W(IW), .USER_W(UW), .RESP_W(RW), .MAX_BEATS(MB)
  ) dut (
    .clk(clk), .reset(reset),
    .io_in_valid(io_in_valid), .io_in_ready(io_in_ready),
    .io_in_bits_data(io_in_bits_data), .io_in_bits_resp(io_in_bits_resp),
    .io_in_bits_id(io_in_bits_id), .io_in_bits_user(io_in_bits_user),
    .io_in_bits_last(io_in_bits_last),
    .io_out_ready(io_out_ready), .io_out_valid(io_out_valid),
    .io_out_bits_data(io_out_bits_data), .io_out_bits_resp(io_out_bits_resp),
    .io_out_bits_id(io_out_bits_id), .io_out_bits_user(io_out_bits_user),
    .io_out_bits_last(io_out_bits_last),
    .grant_idx(grant_idx), .locked(locked),
    .err_burst_len(err_burst_len), .err_clr(err_clr)
  );

  // Three-input instance for the wrap-around selection case.
  logic [2:0]   t3_valid, t3_ready, t3_last, t3_user;
  logic [47:0]  t3_data;
  logic [5:0]   t3_resp;
  logic [11:0]  t3_id;
  logic         t3_out_ready, t3_out_valid, t3_out_last, t3_out_user;
  logic [15:0]  t3_out_data;
  logic [1:0]   t3_out_resp, t3_grant;
  logic [3:0]   t3_out_id;
  logic         t3_locked, t3_err, t3_err_clr;

  junctions_rr_burst_arbiter #(
    .N_IN(3), .DATA_W(16), .ID_W(4), .USER_W(1), .RESP_W(2), .MAX_BEATS(MB)
  ) dut3 (
    .clk(clk), .reset(reset),
    .io_in_valid(t3_valid), .io_in_ready(t3_ready),
    .io_in_bits_data(t3_data), .io_in_bits_resp(t3_resp),
    .io_in_bits_id(t3_id), .io_in_bits_user(t3_user), .io_in_bits_last(t3_last),
    .io_out_ready(t3_out_ready), .io_out_valid(t3_out_valid),
    .io_out_bits_data(t3_out_data), .io_out_bits_resp(t3_out_resp),
    .io_out_bits_id(t3_out_id), .io_out_bits_user(t3_out_user),
    .io_out_bits_last(t3_out_last),
    .grant_idx(t3_grant), .locked(t3_locked),
    .err_burst_len(t3_err), .err_clr(t3_err_clr)
  );

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] ch_dat [N][32];
  logic          ch_last[N][32];
  int            ch_len [N];
  int            ch_pos [N];
  logic [N-1:0]  acc;
  logic          rst_req, out_rdy, clr_req, t3r;
  logic [2:0]    t3v;
  logic [23:0]   exp_q[$];
  logic [23:0]   mon_act, mon_exp;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic load(input int ch, input logic [DW-1:0] d, input logic l);
    ch_dat[ch][ch_len[ch]]  = d;
    ch_last[ch][ch_len[ch]] = l;
    ch_len[ch]++;
  endtask

  task automatic expect_beat(input int ch, input logic [DW-1:0] d, input logic l);
    exp_q.push_back({4'(ch), 2'(ch), 1'(ch), l, d});
  endtask

  task automatic drive();
    reset        = rst_req;
    io_out_ready = out_rdy;
    err_clr      = clr_req;
    t3_valid     = t3v;
    t3_out_ready = t3r;
    for (int i = 0; i < N; i++) begin
      io_in_bits_resp[i*RW +: RW] = RW'(i);
      io_in_bits_id[i*IW +: IW]   = IW'(i);
      io_in_bits_user[i*UW +: UW] = UW'(i);
      if (ch_pos[i] < ch_len[i]) begin
        io_in_valid[i]              = 1'b1;
        io_in_bits_data[i*DW +: DW] = ch_dat[i][ch_pos[i]];
        io_in_bits_last[i]          = ch_last[i][ch_pos[i]];
      end else begin
        io_in_valid[i]              = 1'b0;
        io_in_bits_data[i*DW +: DW] = '0;
        io_in_bits_last[i]          = 1'b0;
      end
    end
  endtask

  // One clock: retire last cycle's handshakes, drive the next beats, sample acceptance.
  task automatic cyc();
    @(posedge clk);
    for (int i = 0; i < N; i++) if (acc[i]) ch_pos[i]++;
    @(negedge clk);
    drive();
    #1;
    acc = reset ? '0 : (io_in_valid & io_in_ready);
  endtask

  always @(negedge clk) begin
    #2;
    if (!reset && io_out_valid && io_out_ready) begin
      mon_act = {io_out_bits_id, io_out_bits_resp, io_out_bits_user, io_out_bits_last, io_out_bits_data};
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL out_unexpected: got %0h with no beat expected", mon_act);
      end else begin
        mon_exp = exp_q.pop_front();
        chk("out_beat", 32'(mon_act), 32'(mon_exp));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int g1[5] = '{0, 1, 2, 3, 0};
    int g2[6] = '{2, 2, 2, 2, 3, 0};
    int lk2[6] = '{0, 1, 1, 1, 0, 0};
    int done;

    rst_req = 1'b1; out_rdy = 1'b1; clr_req = 1'b0;
    t3v = 3'b010; t3r = 1'b0; t3_err_clr = 1'b0;
    t3_data = {16'hA002, 16'hA001, 16'hA000};
    t3_resp = '0; t3_id = '0; t3_user = '0; t3_last = 3'b111;
    acc = '0;
    for (int i = 0; i < N; i++) begin ch_len[i] = 0; ch_pos[i] = 0; end
    drive();
    repeat (3) cyc();
    rst_req = 1'b0;
    cyc();

    // Reset state
    chk("rst_grant", 32'(grant_idx), 0);
    chk("rst_locked", 32'(locked), 0);
    chk("rst_err", 32'(err_burst_len), 0);
    chk("rst_out_valid", 32'(io_out_valid), 0);
    chk("rst_in_ready", 32'(io_in_ready), 32'b0001);

    // Three inputs, pointer at 2
    chk("n3_sel_wrap", 32'(t3_grant), 1);
    chk("n3_out_valid", 32'(t3_out_valid), 1);
    chk("n3_out_data", 32'(t3_out_data), 32'hA001);
    t3v = 3'b000; cyc();
    chk("n3_none_sel", 32'(t3_grant), 0);
    chk("n3_none_valid", 32'(t3_out_valid), 0);
    t3v = 3'b010; t3r = 1'b1; cyc();
    chk("n3_fire_sel", 32'(t3_grant), 1);
    chk("n3_fire_ready", 32'(t3_ready), 32'b010);
    t3v = 3'b001; cyc();
    chk("n3_wrap0_sel", 32'(t3_grant), 0);
    chk("n3_wrap0_ready", 32'(t3_ready), 32'b001);
    t3v = 3'b000; t3r = 1'b0;

    // Single-beat bursts on every input rotate 0,1,2,3,0
    load(0, 16'h1000, 1'b1); load(0, 16'h1004, 1'b1);
    load(1, 16'h1001, 1'b1); load(2, 16'h1002, 1'b1); load(3, 16'h1003, 1'b1);
    expect_beat(0, 16'h1000, 1'b1); expect_beat(1, 16'h1001, 1'b1);
    expect_beat(2, 16'h1002, 1'b1); expect_beat(3, 16'h1003, 1'b1);
    expect_beat(0, 16'h1004, 1'b1);
    for (int k = 0; k < 5; k++) begin
      cyc();
      chk($sformatf("rr_grant%0d", k), 32'(grant_idx), 32'(g1[k]));
    end

    // Four-beat burst from input 2 holds the grant against 0 and 3
    for (int b = 0; b < 4; b++) load(2, 16'h2000 + 16'(b), b == 3);
    load(0, 16'h2100, 1'b1); load(3, 16'h2200, 1'b1);
    for (int b = 0; b < 4; b++) expect_beat(2, 16'h2000 + 16'(b), b == 3);
    expect_beat(3, 16'h2200, 1'b1); expect_beat(0, 16'h2100, 1'b1);
    for (int k = 0; k < 6; k++) begin
      cyc();
      chk($sformatf("burst_grant%0d", k), 32'(grant_idx), 32'(g2[k]));
      chk($sformatf("burst_locked%0d", k), 32'(locked), 32'(lk2[k]));
      chk($sformatf("burst_rdy0_%0d", k), 32'(io_in_ready[0]), 32'(k == 5));
    end
    cyc();
    chk("max_len_legal", 32'(err_burst_len), 0);

    // Six-beat burst with MAX_BEATS=4: error on beat 5, sticky, then cleared
    for (int b = 0; b < 6; b++) begin
      load(1, 16'h3000 + 16'(b), b == 5);
      expect_beat(1, 16'h3000 + 16'(b), b == 5);
    end
    for (int k = 0; k < 6; k++) begin
      cyc();
      chk($sformatf("long_grant%0d", k), 32'(grant_idx), 1);
      chk($sformatf("long_locked%0d", k), 32'(locked), 32'(k != 0));
      chk($sformatf("long_err%0d", k), 32'(err_burst_len), 32'(k == 5));
    end
    cyc();
    chk("err_sticky", 32'(err_burst_len), 1);
    chk("long_unlock", 32'(locked), 0);
    clr_req = 1'b1; cyc();
    chk("err_clr_pending", 32'(err_burst_len), 1);
    clr_req = 1'b0; cyc();
    chk("err_cleared", 32'(err_burst_len), 0);

    // Same with err_clr held high: the set still wins
    clr_req = 1'b1;
    for (int b = 0; b < 6; b++) begin
      load(2, 16'h3100 + 16'(b), b == 5);
      expect_beat(2, 16'h3100 + 16'(b), b == 5);
    end
    for (int k = 0; k < 6; k++) begin
      cyc();
      chk($sformatf("setwin_grant%0d", k), 32'(grant_idx), 2);
      chk($sformatf("setwin_err%0d", k), 32'(err_burst_len), 32'(k == 5));
    end
    cyc();
    chk("setwin_last", 32'(err_burst_len), 1);
    cyc();
    chk("setwin_clr_idle", 32'(err_burst_len), 0);
    clr_req = 1'b0;

    // Reset on beat 2 of a burst from input 3; input 0 then wins
    load(3, 16'h4000, 1'b0); load(3, 16'h4001, 1'b0); load(3, 16'h4002, 1'b1);
    load(0, 16'h4100, 1'b1);
    expect_beat(3, 16'h4000, 1'b0); expect_beat(0, 16'h4100, 1'b1);
    expect_beat(3, 16'h4001, 1'b0); expect_beat(3, 16'h4002, 1'b1);
    cyc();
    chk("mid_grant", 32'(grant_idx), 3);
    chk("mid_ready", 32'(io_in_ready), 32'b1000);
    rst_req = 1'b1; cyc();
    rst_req = 1'b0; cyc();
    chk("post_rst_locked", 32'(locked), 0);
    chk("post_rst_grant", 32'(grant_idx), 0);
    cyc();
    chk("post_rst_resume", 32'(grant_idx), 3);
    cyc();
    chk("post_rst_relock", 32'(locked), 1);

    // Output ready toggling: nothing lost, duplicated or reordered
    load(0, 16'h5000, 1'b0); load(0, 16'h5001, 1'b0); load(0, 16'h5002, 1'b1);
    load(1, 16'h5100, 1'b1);
    expect_beat(0, 16'h5000, 1'b0); expect_beat(0, 16'h5001, 1'b0);
    expect_beat(0, 16'h5002, 1'b1); expect_beat(1, 16'h5100, 1'b1);
    for (int k = 0; k < 12; k++) begin
      out_rdy = (k % 2 == 0);
      cyc();
      if (k % 2 == 1) chk($sformatf("stall_ready%0d", k), 32'(io_in_ready), 0);
    end
    out_rdy = 1'b1;

    for (int t = 0; t < 20 && exp_q.size() != 0; t++) cyc();
    chk("drain_scoreboard", 32'(exp_q.size()), 0);
    done = 0;
    for (int i = 0; i < N; i++) if (ch_pos[i] == ch_len[i]) done++;
    chk("drain_inputs", 32'(done), 32'(N));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
